// File: rtl/dir_manager.sv
// Port-access arbiter for a TIS-100 compute node: handshakes with the four neighbour
// channels for the current instruction's src/dst operands and stalls via clk_en until they finish.
module dir_manager #(
  parameter logic [2:0] TARGET_NIL   = 3'd0,
  parameter logic [2:0] TARGET_ACC   = 3'd1,
  parameter logic [2:0] TARGET_UP    = 3'd2,
  parameter logic [2:0] TARGET_DOWN  = 3'd3,
  parameter logic [2:0] TARGET_LEFT  = 3'd4,
  parameter logic [2:0] TARGET_RIGHT = 3'd5,
  parameter logic [2:0] TARGET_ANY   = 3'd6,
  parameter logic [2:0] TARGET_LAST  = 3'd7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         src,
  input  logic [2:0]         dst,
  input  logic signed [10:0] left_in_data,
  input  logic signed [10:0] right_in_data,
  input  logic signed [10:0] up_in_data,
  input  logic signed [10:0] down_in_data,
  input  logic               left_in_valid,
  input  logic               right_in_valid,
  input  logic               up_in_valid,
  input  logic               down_in_valid,
  output logic               left_in_ready,
  output logic               right_in_ready,
  output logic               up_in_ready,
  output logic               down_in_ready,
  output logic signed [10:0] left_out_data,
  output logic signed [10:0] right_out_data,
  output logic signed [10:0] up_out_data,
  output logic signed [10:0] down_out_data,
  output logic               left_out_valid,
  output logic               right_out_valid,
  output logic               up_out_valid,
  output logic               down_out_valid,
  input  logic               left_out_ready,
  input  logic               right_out_ready,
  input  logic               up_out_ready,
  input  logic               down_out_ready,
  output logic               clk_en,
  output logic signed [10:0] dir_src_data,
  input  logic signed [10:0] dir_dst_data
);

  localparam logic [0:0] PH_READ  = 1'b0;
  localparam logic [0:0] PH_WRITE = 1'b1;

  logic [0:0]         phase_q, phase_d;
  logic               last_vld_q, last_vld_d;
  logic [1:0]         last_idx_q, last_idx_d;
  logic signed [10:0] src_reg_q, src_reg_d;

  // Port vectors are ordered by ANY priority: [0]=LEFT, [1]=RIGHT, [2]=UP, [3]=DOWN.
  logic [3:0]         in_valid_v, out_ready_v, in_ready_v, out_valid_v;
  logic signed [10:0] in_data_a  [4];
  logic signed [10:0] out_data_a [4];

  logic               src_any, dst_any, src_port, dst_port;
  logic [3:0]         src_oh, dst_oh, data_oh, wr_xfer;
  logic               rd_done, wr_done, wr_active;
  logic signed [10:0] rd_data;

  assign in_valid_v  = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
  assign out_ready_v = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};
  assign in_data_a[0] = left_in_data;
  assign in_data_a[1] = right_in_data;
  assign in_data_a[2] = up_in_data;
  assign in_data_a[3] = down_in_data;

  function automatic logic [3:0] dir_sel(input logic [2:0] code, input logic lv,
                                         input logic [1:0] li);
    case (code)
      TARGET_LEFT:            dir_sel = 4'b0001;
      TARGET_RIGHT:           dir_sel = 4'b0010;
      TARGET_UP:              dir_sel = 4'b0100;
      TARGET_DOWN:            dir_sel = 4'b1000;
      TARGET_LAST:            dir_sel = lv ? (4'b0001 << li) : 4'b0000;
      TARGET_NIL, TARGET_ACC: dir_sel = 4'b0000;
      default:                dir_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] first_one(input logic [3:0] v);
    first_one = v & (~v + 4'd1);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] oh);
    case (oh)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  always_comb begin
    src_any   = (src == TARGET_ANY);
    dst_any   = (dst == TARGET_ANY);
    src_oh    = src_any ? first_one(in_valid_v) : dir_sel(src, last_vld_q, last_idx_q);
    src_port  = src_any || (dir_sel(src, last_vld_q, last_idx_q) != 4'b0000);
    dst_port  = dst_any || (dir_sel(dst, last_vld_q, last_idx_q) != 4'b0000);
    rd_done   = src_port && ((src_oh & in_valid_v) != 4'b0000);
    rd_data   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rd_data = rd_data | (in_data_a[i] & {11{src_oh[i]}});
    end

    wr_active = (phase_q == PH_WRITE) || (dst_port && !src_port);
    // ANY destination offers to all ports until one is ready, then commits to the first ready one.
    if (dst_any) begin
      dst_oh  = (out_ready_v != 4'b0000) ? first_one(out_ready_v) : 4'b1111;
      data_oh = 4'b1111;
    end else begin
      dst_oh  = dir_sel(dst, last_vld_q, last_idx_q);
      data_oh = dst_oh;
    end
    out_valid_v = wr_active ? dst_oh : 4'b0000;
    wr_xfer     = out_valid_v & out_ready_v;
    wr_done     = (wr_xfer != 4'b0000);

    in_ready_v   = '0;
    dir_src_data = '0;
    if (phase_q == PH_WRITE) begin
      dir_src_data = src_reg_q;
    end else if (src_port) begin
      in_ready_v   = src_any ? 4'b1111 : src_oh;
      dir_src_data = rd_data;
    end

    if (phase_q == PH_WRITE) clk_en = wr_done;
    else if (!dst_port)      clk_en = src_port ? rd_done : 1'b1;
    else if (!src_port)      clk_en = wr_done;
    else                     clk_en = 1'b0;

    phase_d    = phase_q;
    last_vld_d = last_vld_q;
    last_idx_d = last_idx_q;
    src_reg_d  = src_reg_q;
    if (phase_q == PH_WRITE) begin
      if (wr_done) begin
        phase_d = PH_READ;
        if (dst_any) begin
          last_vld_d = 1'b1;
          last_idx_d = enc(wr_xfer);
        end
      end
    end else begin
      if (rd_done && src_any) begin
        last_vld_d = 1'b1;
        last_idx_d = enc(src_oh);
      end
      if (rd_done && dst_port) begin
        phase_d   = PH_WRITE;
        src_reg_d = rd_data;
      end
      if (!src_port && wr_done && dst_any) begin
        last_vld_d = 1'b1;
        last_idx_d = enc(wr_xfer);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      out_data_a[i] = (wr_active && data_oh[i]) ? dir_dst_data : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_READ;
      last_vld_q <= 1'b0;
      last_idx_q <= 2'd0;
      src_reg_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
      src_reg_q  <= src_reg_d;
    end
  end

  assign left_in_ready   = in_ready_v[0];
  assign right_in_ready  = in_ready_v[1];
  assign up_in_ready     = in_ready_v[2];
  assign down_in_ready   = in_ready_v[3];
  assign left_out_valid  = out_valid_v[0];
  assign right_out_valid = out_valid_v[1];
  assign up_out_valid    = out_valid_v[2];
  assign down_out_valid  = out_valid_v[3];
  assign left_out_data   = out_data_a[0];
  assign right_out_data  = out_data_a[1];
  assign up_out_data     = out_data_a[2];
  assign down_out_data   = out_data_a[3];

endmodule

// File: tb/tb_dir_manager.sv
// Bench for dir_manager: directed scenarios with literal expectations, then randomized
// instructions compared every cycle against an index-based behavioural model.
module tb_dir_manager;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]         src, dst;
  logic [3:0]         ivld, ordy, irdy, ovld;
  logic signed [10:0] idat [4];
  logic signed [10:0] odat [4];
  logic               clk_en;
  logic signed [10:0] dir_src_data, dir_dst_data;

  // Datapath stand-in: MOV-like behaviour with a recognisable constant for NIL source.
  assign dir_dst_data = (src == 3'd0) ? 11'sd999 : dir_src_data;

  dir_manager dut (
    .clk(clk), .reset(reset), .src(src), .dst(dst),
    .left_in_data(idat[0]), .right_in_data(idat[1]), .up_in_data(idat[2]), .down_in_data(idat[3]),
    .left_in_valid(ivld[0]), .right_in_valid(ivld[1]), .up_in_valid(ivld[2]), .down_in_valid(ivld[3]),
    .left_in_ready(irdy[0]), .right_in_ready(irdy[1]), .up_in_ready(irdy[2]), .down_in_ready(irdy[3]),
    .left_out_data(odat[0]), .right_out_data(odat[1]), .up_out_data(odat[2]), .down_out_data(odat[3]),
    .left_out_valid(ovld[0]), .right_out_valid(ovld[1]), .up_out_valid(ovld[2]), .down_out_valid(ovld[3]),
    .left_out_ready(ordy[0]), .right_out_ready(ordy[1]), .up_out_ready(ordy[2]), .down_out_ready(ordy[3]),
    .clk_en(clk_en), .dir_src_data(dir_src_data), .dir_dst_data(dir_dst_data)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          chk_on = 1'b0;

  // Model state: pending write with held value, last ANY port (-1 = none).
  bit                 m_write = 1'b0;
  int                 m_last = -1;
  logic signed [10:0] m_reg = '0;
  bit                 m_retired = 1'b0;

  typedef struct {
    logic [3:0]         irdy;
    logic [3:0]         ovld;
    logic signed [10:0] odat [4];
    logic signed [10:0] src;
    logic               clk_en;
    int                 rd;
    int                 wr;
  } exp_t;

  function automatic int port_of(input logic [2:0] c);
    case (c)
      3'd2:    return 2;
      3'd3:    return 3;
      3'd4:    return 0;
      3'd5:    return 1;
      3'd6:    return 4;
      3'd7:    return m_last;
      default: return -1;
    endcase
  endfunction

  function automatic void compute(output exp_t e);
    int s, d;
    bit writing;
    logic signed [10:0] wdata;
    e.irdy = '0; e.ovld = '0; e.src = '0; e.rd = -1; e.wr = -1;
    for (int i = 0; i < 4; i++) e.odat[i] = '0;
    s = port_of(src);
    d = port_of(dst);
    if (m_write) begin
      e.src = m_reg;
    end else if (s == 4) begin
      e.irdy = 4'b1111;
      for (int i = 0; i < 4; i++) if (ivld[i] && e.rd < 0) e.rd = i;
      if (e.rd >= 0) e.src = idat[e.rd];
    end else if (s >= 0) begin
      e.irdy[s] = 1'b1;
      e.src = idat[s];
      if (ivld[s]) e.rd = s;
    end
    wdata = (src == 3'd0) ? 11'sd999 : e.src;
    writing = m_write || (s < 0 && d >= 0);
    if (writing && d == 4) begin
      for (int i = 0; i < 4; i++) e.odat[i] = wdata;
      for (int i = 0; i < 4; i++) if (ordy[i] && e.wr < 0) e.wr = i;
      if (e.wr >= 0) e.ovld[e.wr] = 1'b1;
      else           e.ovld = 4'b1111;
    end else if (writing && d >= 0) begin
      e.odat[d] = wdata;
      e.ovld[d] = 1'b1;
      if (ordy[d]) e.wr = d;
    end
    if (m_write)    e.clk_en = (e.wr >= 0);
    else if (d < 0) e.clk_en = (s < 0) || (e.rd >= 0);
    else if (s < 0) e.clk_en = (e.wr >= 0);
    else            e.clk_en = 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    exp_t e;
    int s, d;
    if (reset) begin
      m_write <= 1'b0; m_last <= -1; m_reg <= '0; m_retired <= 1'b0;
    end else begin
      compute(e);
      s = port_of(src);
      d = port_of(dst);
      m_retired <= e.clk_en;
      if (m_write) begin
        if (e.wr >= 0) begin
          m_write <= 1'b0;
          if (d == 4) m_last <= e.wr;
        end
      end else begin
        if (e.rd >= 0 && s == 4) m_last <= e.rd;
        if (e.rd >= 0 && d >= 0) begin
          m_write <= 1'b1;
          m_reg   <= e.src;
        end
        if (s < 0 && e.wr >= 0 && d == 4) m_last <= e.wr;
      end
    end
  end

  function automatic void cmp(input string name, input logic signed [31:0] got,
                              input logic signed [31:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t src=%0d dst=%0d)", name, got, want,
               $time, src, dst);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      compute(e);
      n_vec++;
      cmp("in_ready", {28'd0, irdy}, {28'd0, e.irdy});
      cmp("out_valid", {28'd0, ovld}, {28'd0, e.ovld});
      for (int i = 0; i < 4; i++) cmp("out_data", odat[i], e.odat[i]);
      cmp("dir_src_data", dir_src_data, e.src);
      cmp("clk_en", {31'd0, clk_en}, {31'd0, e.clk_en});
    end
  end

  function automatic void lit(input string name, input logic signed [31:0] got,
                              input logic signed [31:0] want);
    n_vec++;
    cmp(name, got, want);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic [2:0] s, input logic [2:0] d, input logic [3:0] v,
                      input logic [3:0] r);
    src = s; dst = d; ivld = v; ordy = r;
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    setv(3'd0, 3'd0, 4'b0000, 4'b0000);
    idat[0] = 11'sd1; idat[1] = 11'sd2; idat[2] = 11'sd3; idat[3] = 11'sd4;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    #2;
    lit("reset_clk_en", {31'd0, clk_en}, 1);
    lit("reset_in_ready", {28'd0, irdy}, 0);
    lit("reset_src_data", dir_src_data, 0);
    step();
    reset = 1'b0;

    // LEFT -> ACC
    setv(3'd4, 3'd1, 4'b0000, 4'b0000); #2;
    lit("left_ready", {31'd0, irdy[0]}, 1);
    lit("left_wait_clk_en", {31'd0, clk_en}, 0);
    step();
    ivld = 4'b0001; #2;
    lit("left_data", dir_src_data, 1);
    lit("left_done_clk_en", {31'd0, clk_en}, 1);
    step();

    // NIL -> UP
    setv(3'd0, 3'd2, 4'b0000, 4'b0000); #2;
    lit("up_valid", {31'd0, ovld[2]}, 1);
    lit("up_data", odat[2], 999);
    lit("up_wait_clk_en", {31'd0, clk_en}, 0);
    step();
    ordy = 4'b0100; #2;
    lit("up_done_clk_en", {31'd0, clk_en}, 1);
    step();
    setv(3'd0, 3'd0, 4'b0000, 4'b0000); #2;
    lit("up_valid_after", {31'd0, ovld[2]}, 0);
    step();

    // RIGHT -> DOWN through the WRITE phase
    setv(3'd5, 3'd3, 4'b0010, 4'b0000); #2;
    lit("rd_right_ready", {31'd0, irdy[1]}, 1);
    lit("rd_clk_en", {31'd0, clk_en}, 0);
    step(); #2;
    lit("wr_right_ready", {31'd0, irdy[1]}, 0);
    lit("wr_down_valid", {31'd0, ovld[3]}, 1);
    lit("wr_down_data", odat[3], 2);
    lit("wr_wait_clk_en", {31'd0, clk_en}, 0);
    step();
    ordy = 4'b1000; #2;
    lit("wr_done_clk_en", {31'd0, clk_en}, 1);
    step();
    setv(3'd5, 3'd3, 4'b0000, 4'b0000); #2;
    lit("back_read_ready", {31'd0, irdy[1]}, 1);
    lit("back_read_valid", {31'd0, ovld[3]}, 0);
    setv(3'd0, 3'd1, 4'b0000, 4'b0000);
    step();

    // ANY read, then LAST follows the port it used
    setv(3'd6, 3'd1, 4'b1100, 4'b0000); #2;
    lit("any_data", dir_src_data, 3);
    lit("any_clk_en", {31'd0, clk_en}, 1);
    step();
    setv(3'd7, 3'd1, 4'b0100, 4'b0000); #2;
    lit("last_up_ready", {31'd0, irdy[2]}, 1);
    lit("last_data", dir_src_data, 3);
    step();

    // LAST right after reset behaves as NIL
    reset = 1'b1;
    step();
    reset = 1'b0;
    setv(3'd7, 3'd1, 4'b0000, 4'b0000); #2;
    lit("last_nil_ready", {28'd0, irdy}, 0);
    lit("last_nil_data", dir_src_data, 0);
    lit("last_nil_clk_en", {31'd0, clk_en}, 1);
    step();

    // Reset in the middle of a WRITE
    setv(3'd4, 3'd5, 4'b0001, 4'b0000);
    step(); #2;
    lit("pre_reset_valid", {31'd0, ovld[1]}, 1);
    reset = 1'b1; #1;
    lit("reset_abort_valid", {28'd0, ovld}, 0);
    lit("reset_abort_clk_en", {31'd0, clk_en}, 0);
    step();
    reset = 1'b0;
    setv(3'd0, 3'd0, 4'b0000, 4'b0000);
    step();

    // Randomized instructions; src/dst held until the instruction retires
    for (int t = 0; t < 300; t++) begin
      src = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      cyc = 0;
      do begin
        ivld = 4'($urandom);
        ordy = 4'($urandom);
        for (int i = 0; i < 4; i++) idat[i] = 11'($urandom);
        if ($urandom_range(0, 63) == 0) begin
          #2 reset = 1'b1;
        end
        step();
        reset = 1'b0;
        cyc++;
      end while (!m_retired && cyc < 40);
      if (!m_retired) begin
        n_bad++;
        $display("FAIL retire_timeout: instruction src=%0d dst=%0d not retired after %0d cycles",
                 src, dst, cyc);
      end
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
